ssd_scan_decoder: RTL
=====================

Name: ssd_scan_decoder

Overview:
- Reader/monitor for the multiplexed 4-digit seven-segment display bus driven by the processor's display path.
- Samples the active-low anode and segment lines and filters out scan transitions.
- Decodes each settled segment pattern back to its hex nibble and assembles a 16-bit displayed value, with per-digit error and blank flags.
- Used on the board as a loopback/self-check of the display path and in simulation as a display scoreboard source.

Parameters:
- STABLE_CYC, 4, consecutive identical (an, seg) samples required before a digit is accepted; range 1..255.
- TIMEOUT_CYC, 1000000, cycles without a complete frame before stale asserts; range 2..2^24-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- an  input  4  digit enables, active-low, one-hot-low; bit0 = rightmost digit (value[3:0])
- seg  input  7  segments, active-low; bit6 = a, bit5 = b, ... bit0 = g
- value  output  16  last completed frame, digit3 in [15:12] down to digit0 in [3:0]
- frame_valid  output  1  one-cycle pulse when value/digit_err/digit_blank update
- digit_err  output  4  per digit: pattern not in the code table and not blank
- digit_blank  output  4  per digit: pattern 7'b1111111
- stale  output  1  no frame completed within TIMEOUT_CYC

Behaviour:
- Reset (rst_n=0 at posedge): value=0, frame_valid=0, digit_err=0, digit_blank=0, stale=0; all internal counters, the seen mask and the digit staging registers are cleared. Reset mid-frame discards any partial frame.
- Inputs are registered once (sample stage), then compared with the previous sample.
- Stability counter:
  - Increments while the sample equals the previous sample; reloads to 1 on any change.
  - Saturates at STABLE_CYC. The accept event occurs exactly once, on the cycle the count reaches STABLE_CYC.
- Accept is valid only if an has exactly one zero bit. Patterns with 4'b1111 (idle) or multiple lows are ignored: no accept, no error.
- On accept of digit k:
  - Decode seg through the code table into stage[k] nibble, err_k, blank_k.
  - Set seen[k]. A re-accept of an already-seen digit overwrites stage[k].
- Code table (seg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
- Non-table patterns:
  - 1111111 -> nibble 0, blank=1, err=0.
  - Any other pattern -> nibble 0, err=1.
- Frame completion:
  - When seen becomes 4'b1111, the next cycle copies stage/err/blank to the outputs, pulses frame_valid for 1 cycle, clears seen, clears stale and resets the timeout counter.
  - An accept arriving in the completion cycle counts toward the next frame.
- Latency: from the first cycle the final digit's stable pattern appears on the pins to frame_valid is STABLE_CYC+2 cycles (1 sample + STABLE_CYC-1 compare + 1 complete + 1 output).
- Timeout:
  - The counter increments every cycle without a completion.
  - On reaching TIMEOUT_CYC-1, stale is set and the counter holds.
  - value is not cleared on timeout.
- State machine over the frame: IDLE (seen=0) -> COLLECT (some seen) -> COMPLETE (1 cycle) -> IDLE. A scan order other than 0..3 is legal; only the set of digits matters.

Decomposition:
- Shared package ssd_pkg holds:
  - the 16-entry segment code constants, shared with the encoder side;
  - SEG_BLANK = 7'h7F;
  - the digit count constant NUM_DIGITS = 4.
- One sub-module: ssd_pattern_decode, a combinational seg -> {nibble, err, blank} built from the package table.

Test Plan:
- Reset: hold rst_n=0 with arbitrary an/seg for 5 cycles -> value=0000, frame_valid=0, stale=0. Release rst_n -> all outputs still 0 before any accept.
- Normal scan: display 0x1A3F, each digit held 16 cycles, scan order 0..3 -> single frame_valid with value=16'h1A3F, digit_err=0, digit_blank=0. Latency from the digit3 pattern first appearing = STABLE_CYC+2.
- Glitch filter, STABLE_CYC=4: a 3-cycle wrong pattern on a digit followed by the correct one -> the glitch is never accepted and the value is correct.
- Blank/illegal: digit2 = 1111111, digit1 = 1010101 -> digit_blank=4'b0100, digit_err=4'b0010, nibbles 0.
- Bad anodes: an=4'b1111 and an=4'b0011 held 20 cycles -> no accept and no frame_valid.
- Timeout/reset: with TIMEOUT_CYC=50, stop scanning -> stale=1 at cycle 49 after the last completion and value is retained. The next full frame clears stale. Asserting rst_n low mid-frame (2 digits seen) -> the next frame requires all 4 digits.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display path: segment code table,
// blank pattern, digit count, decoder result type and frame FSM encodings.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_CODES  = 16;

    // Active-low segments, bit6 = a ... bit0 = g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index is the hex nibble shown by the pattern; shared with the encoder side.
    localparam logic [6:0] SEG_CODE [NUM_CODES] = '{
        7'b0000001,   // 0
        7'b1001111,   // 1
        7'b0010010,   // 2
        7'b0000110,   // 3
        7'b1001100,   // 4
        7'b0100100,   // 5
        7'b0100000,   // 6
        7'b0001111,   // 7
        7'b0000000,   // 8
        7'b0000100,   // 9
        7'b0001000,   // A
        7'b1100000,   // b
        7'b0110001,   // C
        7'b1000010,   // d
        7'b0110000,   // E
        7'b0111000    // F
    };

    typedef struct packed {
        logic [3:0] nibble;
        logic       err;
        logic       blank;
    } seg_decode_t;

    // Frame collection states.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational reverse lookup of a segment pattern into its hex nibble,
// flagging the all-off blank pattern and anything outside the code table.
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0]  seg,
    output seg_decode_t dec
);

    // Search the code table; a blank pattern is legal and decodes to zero.
    always_comb begin
        // NOTE: every output gets a default before the search, so no latch is inferred.
        dec = '{nibble: 4'd0, err: 1'b1, blank: 1'b0};
        if (seg == SEG_BLANK) begin
            dec.err   = 1'b0;
            dec.blank = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CODES; i++) begin
                if (seg == SEG_CODE[i]) begin
                    dec.nibble = 4'(i);
                    dec.err    = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Monitors a multiplexed 4-digit seven-segment bus, filters scan transitions,
// decodes each settled digit and publishes a full 16-bit frame once every
// digit has been seen. Raises stale when no frame completes in time.
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_err,
    output logic [3:0]  digit_blank,
    output logic        stale
);

    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYC);
    localparam logic [23:0] TIMEOUT_MAX = 24'(TIMEOUT_CYC - 1);

    // Sample stage and previous sample.
    logic [3:0] an_s_q,  an_s_d,  an_p_q,  an_p_d;
    logic [6:0] seg_s_q, seg_s_d, seg_p_q, seg_p_d;

    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [23:0] to_cnt_q,   to_cnt_d;
    logic [1:0]  state_q,    state_d;

    logic [NUM_DIGITS-1:0]       seen_q,        seen_d;
    logic [NUM_DIGITS-1:0][3:0]  stage_nib_q,   stage_nib_d;
    logic [NUM_DIGITS-1:0]       stage_err_q,   stage_err_d;
    logic [NUM_DIGITS-1:0]       stage_blank_q, stage_blank_d;

    logic [15:0] value_q,       value_d;
    logic        frame_valid_q, frame_valid_d;
    logic [3:0]  digit_err_q,   digit_err_d;
    logic [3:0]  digit_blank_q, digit_blank_d;
    logic        stale_q,       stale_d;

    logic        same;
    logic        an_ok;
    logic [1:0]  dig_idx;
    logic        accept;
    logic        complete;
    seg_decode_t seg_dec;

    ssd_pattern_decode u_decode (
        .seg (seg_s_q),
        .dec (seg_dec)
    );

    // Map the sampled anodes to a digit index; idle or multi-low patterns are ignored.
    always_comb begin
        an_ok   = 1'b1;
        dig_idx = 2'd0;
        case (an_s_q)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: an_ok   = 1'b0;
        endcase
    end

    // Next-state logic: stability filter, digit staging, frame FSM, timeout.
    always_comb begin
        an_s_d  = an;
        seg_s_d = seg;
        an_p_d  = an_s_q;
        seg_p_d = seg_s_q;

        // Stability counter: reload on change, saturate at the accept count.
        same = (an_s_q == an_p_q) && (seg_s_q == seg_p_q);
        if (!same) begin
            stab_cnt_d = 8'd1;
        end else if (stab_cnt_q != STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        // Fires only on the cycle the count arrives at the limit, never while parked there.
        accept = an_ok && (stab_cnt_d == STABLE_MAX) && (!same || stab_cnt_q != STABLE_MAX);

        complete      = (state_q == ST_COMPLETE);
        seen_d        = complete ? '0 : seen_q;
        stage_nib_d   = stage_nib_q;
        stage_err_d   = stage_err_q;
        stage_blank_d = stage_blank_q;
        if (accept) begin
            seen_d[dig_idx]        = 1'b1;
            stage_nib_d[dig_idx]   = seg_dec.nibble;
            stage_err_d[dig_idx]   = seg_dec.err;
            stage_blank_d[dig_idx] = seg_dec.blank;
        end

        if (seen_d == '1) begin
            state_d = ST_COMPLETE;
        end else if (seen_d != '0) begin
            state_d = ST_COLLECT;
        end else begin
            state_d = ST_IDLE;
        end

        frame_valid_d = complete;
        value_d       = complete ? stage_nib_q   : value_q;
        digit_err_d   = complete ? stage_err_q   : digit_err_q;
        digit_blank_d = complete ? stage_blank_q : digit_blank_q;

        if (complete) begin
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end else begin
            to_cnt_d = (to_cnt_q != TIMEOUT_MAX) ? to_cnt_q + 24'd1 : to_cnt_q;
            stale_d  = stale_q || (to_cnt_d == TIMEOUT_MAX);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst_n) begin
            an_s_q        <= 4'hF;
            an_p_q        <= 4'hF;
            seg_s_q       <= SEG_BLANK;
            seg_p_q       <= SEG_BLANK;
            stab_cnt_q    <= '0;
            to_cnt_q      <= '0;
            state_q       <= ST_IDLE;
            seen_q        <= '0;
            // NOTE: staging registers are reset too, so a frame cut short by reset cannot leak old digits.
            stage_nib_q   <= '0;
            stage_err_q   <= '0;
            stage_blank_q <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            digit_err_q   <= '0;
            digit_blank_q <= '0;
            stale_q       <= 1'b0;
        end else begin
            an_s_q        <= an_s_d;
            an_p_q        <= an_p_d;
            seg_s_q       <= seg_s_d;
            seg_p_q       <= seg_p_d;
            stab_cnt_q    <= stab_cnt_d;
            to_cnt_q      <= to_cnt_d;
            state_q       <= state_d;
            seen_q        <= seen_d;
            stage_nib_q   <= stage_nib_d;
            stage_err_q   <= stage_err_d;
            stage_blank_q <= stage_blank_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            digit_err_q   <= digit_err_d;
            digit_blank_q <= digit_blank_d;
            stale_q       <= stale_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign digit_err   = digit_err_q;
    assign digit_blank = digit_blank_q;
    assign stale       = stale_q;

endmodule
